// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types and defaults for the accumulator arbiter
// Contents: sequencer state encoding, one-hot grant encodings, default widths.
package accum_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_KEY  = 2'b01,
        GNT_TICK = 2'b10
    } grant_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 4;

endpackage

// File: rtl/accum_arbiter_if.sv
// rtl/accum_arbiter_if.sv - request/operand inputs and accumulator status outputs
// master: front-end side (drives clear/requests/operands/run, observes status).
// slave:  accum_arbiter side.
interface accum_arbiter_if
    import accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
);
    logic             clear_i;
    logic             req_key_i;
    logic [OPW-1:0]   op_key_i;
    logic             run_i;
    logic [OPW-1:0]   op_tick_i;
    logic [WIDTH-1:0] acc_o;
    logic             ovf_o;
    logic             drop_o;
    logic [1:0]       grant_o;
    logic             busy_o;
    logic             tick_o;

    modport master (
        output clear_i, req_key_i, op_key_i, run_i, op_tick_i,
        input  acc_o, ovf_o, drop_o, grant_o, busy_o, tick_o
    );

    modport slave (
        input  clear_i, req_key_i, op_key_i, run_i, op_tick_i,
        output acc_o, ovf_o, drop_o, grant_o, busy_o, tick_o
    );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - periodic auto-tick prescaler
// Ports: clk100_i, rstn_i (async active-low), run_i (count enable),
//        tick_o (registered one-cycle pulse, once per TICK_DIV running cycles).
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic run_i,
    output logic tick_o
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_top;

    assign at_top = (cnt == CW'(TICK_DIV - 1));

    // run_i low freezes the count so pausing does not restart the period.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= run_i && at_top;
            if (run_i) begin
                cnt <= at_top ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/accum_arbiter.sv
// rtl/accum_arbiter.sv - round-robin sharing of one accumulator between key and tick
// Ports: clk100_i, rstn_i (async active-low); bus (slave): clear_i, req_key_i,
//        op_key_i, run_i, op_tick_i in; acc_o, ovf_o, drop_o, grant_o, busy_o,
//        tick_o out. All outputs are registered.
module accum_arbiter
    import accum_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int OPW      = DEF_OPW,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic            clk100_i,
    input  logic            rstn_i,
    accum_arbiter_if.slave  bus
);
    state_t           state, state_n;
    grant_t           grant, grant_n;
    logic             last_tick, last_tick_n;  // 1: tick was served last
    logic [WIDTH-1:0] acc, acc_n;
    logic             ovf, ovf_n, drop, drop_n;
    logic             pend_key, pend_key_n, pend_tick, pend_tick_n;
    logic [OPW-1:0]   op_key_q, op_key_n, op_tick_q, op_tick_n;
    logic [OPW-1:0]   op_sel;
    logic [WIDTH:0]   sum;
    logic             tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk100_i (clk100_i),
        .rstn_i   (rstn_i),
        .run_i    (bus.run_i),
        .tick_o   (tick)
    );

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            grant     <= GNT_NONE;
            last_tick <= 1'b1;
            acc       <= '0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
            pend_key  <= 1'b0;
            pend_tick <= 1'b0;
            op_key_q  <= '0;
            op_tick_q <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            last_tick <= last_tick_n;
            acc       <= acc_n;
            ovf       <= ovf_n;
            drop      <= drop_n;
            pend_key  <= pend_key_n;
            pend_tick <= pend_tick_n;
            op_key_q  <= op_key_n;
            op_tick_q <= op_tick_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        last_tick_n = last_tick;
        acc_n       = acc;
        ovf_n       = ovf;
        drop_n      = drop;
        pend_key_n  = pend_key;
        pend_tick_n = pend_tick;
        op_key_n    = op_key_q;
        op_tick_n   = op_tick_q;
        op_sel      = (grant == GNT_TICK) ? op_tick_q : op_key_q;
        sum         = {1'b0, acc} + {{(WIDTH + 1 - OPW){1'b0}}, op_sel};

        if (bus.clear_i) begin
            state_n     = IDLE;
            grant_n     = GNT_NONE;
            acc_n       = '0;
            ovf_n       = 1'b0;
            drop_n      = 1'b0;
            pend_key_n  = 1'b0;
            pend_tick_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_key || pend_tick) begin
                        // On a tie the source not served last wins.
                        if (pend_tick && (!pend_key || !last_tick)) begin
                            grant_n     = GNT_TICK;
                            last_tick_n = 1'b1;
                        end else begin
                            grant_n     = GNT_KEY;
                            last_tick_n = 1'b0;
                        end
                        state_n = ADD;
                    end
                end
                ADD: begin
                    acc_n = sum[WIDTH-1:0];
                    ovf_n = ovf | sum[WIDTH];
                    if (grant == GNT_TICK) pend_tick_n = 1'b0;
                    else                   pend_key_n  = 1'b0;
                    state_n = IDLE;
                    grant_n = GNT_NONE;
                end
                default: state_n = IDLE;
            endcase

            // Capture sees the pending flag after this cycle's ADD release,
            // so a request in the releasing cycle becomes a fresh pending.
            if (bus.req_key_i) begin
                if (pend_key_n) drop_n = 1'b1;
                else begin
                    pend_key_n = 1'b1;
                    op_key_n   = bus.op_key_i;
                end
            end
            if (tick) begin
                if (pend_tick_n) drop_n = 1'b1;
                else begin
                    pend_tick_n = 1'b1;
                    op_tick_n   = bus.op_tick_i;
                end
            end
        end
    end

    assign bus.acc_o   = acc;
    assign bus.ovf_o   = ovf;
    assign bus.drop_o  = drop;
    assign bus.grant_o = grant;
    assign bus.busy_o  = (state == ADD);
    assign bus.tick_o  = tick;
endmodule

// File: tb/tb_accum_arbiter.sv
// tb/tb_accum_arbiter.sv - directed self-checking bench for accum_arbiter
module tb_accum_arbiter;
    logic clk100_i = 1'b0;
    logic rstn_i   = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    accum_arbiter_if #(.WIDTH(8), .OPW(4)) bus ();

    accum_arbiter #(.WIDTH(8), .OPW(4), .TICK_DIV(4)) dut (
        .clk100_i (clk100_i),
        .rstn_i   (rstn_i),
        .bus      (bus.slave)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk100_i);
        rstn_i        = 1'b0;
        bus.clear_i   = 1'b0;
        bus.req_key_i = 1'b0;
        bus.op_key_i  = '0;
        bus.run_i     = 1'b0;
        bus.op_tick_i = '0;
        @(negedge clk100_i);
        rstn_i = 1'b1;
    endtask

    // Single key request; returns at the negedge after the accumulator update.
    task automatic do_key(input logic [3:0] op);
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = op;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        @(negedge clk100_i);
        @(negedge clk100_i);
    endtask

    // Key request placed in the very cycle the tick fires; checks grant order.
    task automatic tie(input string tag, input logic [1:0] g1, input logic [7:0] a1,
                       input logic [1:0] g2, input logic [7:0] a2);
        bit found = 0;
        bus.op_tick_i = 4'd2;
        bus.run_i     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk100_i);
            if (bus.tick_o) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_tick_seen"}, 32'(found), 32'd1);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd1;
        bus.run_i     = 1'b0;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        @(negedge clk100_i);
        chk({tag, "_grant1"}, 32'(bus.grant_o), 32'(g1));
        @(negedge clk100_i);
        chk({tag, "_acc1"}, 32'(bus.acc_o), 32'(a1));
        @(negedge clk100_i);
        chk({tag, "_grant2"}, 32'(bus.grant_o), 32'(g2));
        @(negedge clk100_i);
        chk({tag, "_acc2"}, 32'(bus.acc_o), 32'(a2));
    endtask

    initial begin
        int ticks;
        int last_cyc;

        // 1: reset state and single key request latency
        bus.clear_i = 0; bus.req_key_i = 0; bus.op_key_i = 0;
        bus.run_i = 0; bus.op_tick_i = 0;
        #1;
        chk("rst_acc",   32'(bus.acc_o),   32'h0);
        chk("rst_busy",  32'(bus.busy_o),  32'h0);
        chk("rst_grant", 32'(bus.grant_o), 32'h0);
        chk("rst_flags", {30'd0, bus.ovf_o, bus.drop_o}, 32'h0);
        chk("rst_tick",  32'(bus.tick_o),  32'h0);
        do_reset();
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd5;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        chk("t1_busy_c1", 32'(bus.busy_o), 32'h0);
        @(negedge clk100_i);
        chk("t1_busy_c2",  32'(bus.busy_o),  32'h1);
        chk("t1_grant_c2", 32'(bus.grant_o), 32'h1);
        chk("t1_acc_c2",   32'(bus.acc_o),   32'h0);
        @(negedge clk100_i);
        chk("t1_acc_c3",   32'(bus.acc_o),   32'h05);
        chk("t1_grant_c3", 32'(bus.grant_o), 32'h0);
        chk("t1_flags", {30'd0, bus.ovf_o, bus.drop_o}, 32'h0);

        // 2: wrap and sticky overflow
        do_reset();
        for (int i = 0; i < 16; i++) do_key(4'd15);
        do_key(4'd14);
        chk("t2_acc_fe", 32'(bus.acc_o), 32'hFE);
        chk("t2_ovf_0",  32'(bus.ovf_o), 32'h0);
        do_key(4'd3);
        chk("t2_acc_wrap", 32'(bus.acc_o), 32'h01);
        chk("t2_ovf_1",    32'(bus.ovf_o), 32'h1);
        do_key(4'd1);
        chk("t2_acc_02",    32'(bus.acc_o), 32'h02);
        chk("t2_ovf_stick", 32'(bus.ovf_o), 32'h1);

        // 3: round-robin ties
        do_reset();
        tie("t3_tie1", 2'b01, 8'd1, 2'b10, 8'd3);
        do_key(4'd1);
        chk("t3_acc_4", 32'(bus.acc_o), 32'd4);
        tie("t3_tie2", 2'b10, 8'd6, 2'b01, 8'd7);
        chk("t3_drop", 32'(bus.drop_o), 32'h0);

        // 4: back-to-back key requests -> second dropped
        do_reset();
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd4;
        @(negedge clk100_i);
        bus.op_key_i  = 4'd7;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        repeat (4) @(negedge clk100_i);
        chk("t4_acc",  32'(bus.acc_o),  32'd4);
        chk("t4_drop", 32'(bus.drop_o), 32'h1);

        // 5: free-running tick, period 4, 40 cycles
        do_reset();
        bus.op_tick_i = 4'd1;
        bus.run_i     = 1'b1;
        ticks    = 0;
        last_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk100_i);
            if (bus.tick_o) begin
                if (last_cyc >= 0) chk("t5_tick_period", 32'(c - last_cyc), 32'd4);
                last_cyc = c;
                ticks++;
            end
        end
        bus.run_i = 1'b0;
        repeat (4) @(negedge clk100_i);
        chk("t5_ticks", 32'(ticks),        32'd10);
        chk("t5_acc",   32'(bus.acc_o),    32'd10);
        chk("t5_drop",  32'(bus.drop_o),   32'h0);

        // 6: clear during ADD, then async reset during ADD
        do_reset();
        do_key(4'd15);
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd1;
        @(negedge clk100_i);
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        repeat (3) @(negedge clk100_i);
        chk("t6_acc_10", 32'(bus.acc_o),  32'h10);
        chk("t6_drop_1", 32'(bus.drop_o), 32'h1);
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd5;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        @(negedge clk100_i);
        chk("t6_busy_pre_clr", 32'(bus.busy_o), 32'h1);
        bus.clear_i = 1'b1;
        @(negedge clk100_i);
        bus.clear_i = 1'b0;
        chk("t6_clr_acc",   32'(bus.acc_o),   32'h0);
        chk("t6_clr_flags", {30'd0, bus.ovf_o, bus.drop_o}, 32'h0);
        chk("t6_clr_busy",  32'(bus.busy_o),  32'h0);
        chk("t6_clr_grant", 32'(bus.grant_o), 32'h0);
        repeat (3) @(negedge clk100_i);
        chk("t6_clr_stays", 32'(bus.acc_o), 32'h0);
        do_key(4'd9);
        chk("t6_acc_9", 32'(bus.acc_o), 32'h9);
        @(negedge clk100_i);
        bus.req_key_i = 1'b1;
        bus.op_key_i  = 4'd3;
        @(negedge clk100_i);
        bus.req_key_i = 1'b0;
        @(negedge clk100_i);
        chk("t6_busy_pre_rst", 32'(bus.busy_o), 32'h1);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_acc",   32'(bus.acc_o),   32'h0);
        chk("t6_rst_busy",  32'(bus.busy_o),  32'h0);
        chk("t6_rst_grant", 32'(bus.grant_o), 32'h0);
        @(negedge clk100_i);
        rstn_i = 1'b1;
        repeat (3) @(negedge clk100_i);
        chk("t6_rst_no_add", 32'(bus.acc_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/accum_arbiter.md
# accum_arbiter

Shares the single 8-bit accumulator of the board counter datapath between two requesters. The first is the debounced push-button pulse, with its operand on switches. The second is an internal periodic auto-tick, with its operand on a second switch group. Pending requests are captured, granted round-robin, and applied one at a time through a two-state sequencer. Sits between the debounce/switch front-end and the hex-display decoders, which consume `acc_o`.

## Interface
- `WIDTH`, 8: accumulator width.
- `OPW`, 4: operand width, zero-extended to `WIDTH`.
- `TICK_DIV`, 100_000_000: auto-tick period in `clk100_i` cycles; must be ≥ 2.
- `clk100_i` in 1: system clock; all state changes on the rising edge.
- `rstn_i` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear of the accumulator, flags and pending requests.
- `req_key_i` in 1: one-cycle request pulse from the debouncer.
- `op_key_i` in OPW: key operand, sampled in the cycle `req_key_i`=1.
- `run_i` in 1: enables auto-tick generation.
- `op_tick_i` in OPW: tick operand, sampled in the cycle the internal tick fires.
- `acc_o` out WIDTH: accumulator value.
- `ovf_o` out 1: sticky carry-out of any addition.
- `drop_o` out 1: sticky; a request arrived while the same source was already pending.
- `grant_o` out 2: one-hot grant during ADD; [0]=key, [1]=tick.
- `busy_o` out 1: 1 while state is ADD.
- `tick_o` out 1: one-cycle pulse when the internal tick fires.

## Operation
- **Reset values:** `acc_o`=0, `ovf_o`=0, `drop_o`=0, `grant_o`=00, `busy_o`=0, `tick_o`=0, state IDLE, both pending flags 0, prescaler 0, last-served pointer=tick (so key wins the first tie).
- **Prescaler:**
  - While `run_i`=1, counts 0..TICK_DIV-1 and fires `tick_o` in the cycle it reaches TICK_DIV-1, then wraps to 0.
  - `run_i`=0 holds the count; it does not reset it.
- **Capture (per source):**
  - A request while not pending sets pending and latches the operand.
  - A request while pending is discarded, sets `drop_o`, and leaves the latched operand unchanged.
  - A pending flag clears on the edge that ends its ADD cycle. A new request from the same source in that same cycle is captured as a fresh pending (not a drop).
- **FSM:**
  - IDLE: if any source is pending, select one. A single pending source is selected; if both are pending, select the one not last served. Go to ADD with `grant_o` set and the last-served pointer updated. Otherwise stay in IDLE.
  - ADD: `acc <= acc + zext(op_sel)` modulo 2^WIDTH. Carry-out sets `ovf_o`. Clear the selected pending flag, go to IDLE, `grant_o` → 00.
- **Arithmetic:** `WIDTH+1`-bit sum; the top bit feeds `ovf_o`. The accumulator wraps, e.g. 0xFE+3 → 0x01.
- **clear_i:** highest priority in every state.
  - Next edge sets acc=0, `ovf_o`=0, `drop_o`=0, both pending=0, state IDLE, `grant_o`=00.
  - Any ADD in progress is abandoned with no acc update.
  - Requests arriving in a `clear_i` cycle are discarded.
  - The prescaler is not affected.
- **Reset mid-operation:** returns immediately to the reset values; no partial update survives.

## Timing
- Request at cycle 0 → pending at edge 1 → ADD (`busy_o`, `grant_o`) in cycle 2 → `acc_o` updated after edge 3. Latency is 3 cycles from request to `acc_o`.
- Throughput: one addition per 2 cycles (IDLE→ADD→IDLE).
- With both sources continuously pending, grants alternate key, tick, key, …
- `tick_o` is a single-cycle pulse. Its capture follows the same timing as `req_key_i`.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `accum_pkg`:
  - state encoding: IDLE=1'b0, ADD=1'b1;
  - grant encodings: GNT_NONE, GNT_KEY, GNT_TICK;
  - default `WIDTH`/`OPW` constants.
- Sub-module `tick_gen` (prescaler: `clk100_i`, `rstn_i`, `run_i` → `tick_o`), parameterised by `TICK_DIV`.
- Capture logic, arbiter and FSM live in the top module.

## Test plan
1. Reset, `TICK_DIV`=4, `run_i`=0; key request with `op_key_i`=5 → `busy_o`/`grant_o`=01 in cycle 2, `acc_o`=0x05 after edge 3, flags 0.
2. `acc_o`=0xFE, key request with op 3 → `acc_o`=0x01, `ovf_o`=1. A further op 1 → 0x02, `ovf_o` still 1.
3. Key request and tick in the same cycle, ops 1 and 2, first tie after reset → key granted first (acc=1), then tick (acc=3). Next tie → key is granted second.
4. Two key requests 1 cycle apart (ops 4, 7) → first captured, second dropped; `acc_o`=4 and `drop_o`=1.
5. `run_i`=1, `TICK_DIV`=4, `op_tick_i`=1, 40 cycles → `tick_o` every 4 cycles, acc increments by 1 per tick, no drops.
6. `clear_i` asserted during ADD with `acc_o`=0x10 → next edge acc=0, `ovf_o`/`drop_o`=0, IDLE; async `rstn_i` pulse mid-ADD → all outputs at reset values immediately.
